fetch_unit: RTL



---
 rtl/fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: turns PC advances into imem requests, matches in-order responses to
// their PCs, buffers them for decode and squashes wrong-path work on redirect (FETCH_BYPASS_EN).
module fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic        pc_select,
   output logic        pc_stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {FETCH, REPLAY} state_t;

   state_t          state_q, state_d;
   logic            first_q, first_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d, buf_cnt_q, buf_cnt_d, kill_q, kill_d;
   logic [AW-1:0]   pcf_wr_q, pcf_rd_q, ib_wr_q, ib_rd_q;
   logic [31:0]     pcf_mem [DEPTH];
   logic [31:0]     ib_pc   [DEPTH];
   logic [31:0]     ib_data [DEPTH];

   logic [CW-1:0]   occ;
   logic            accept, kill_nz, resp_live, byp, push, pop, iv_buf;
   logic            unused_addr_lsbs;

   assign unused_addr_lsbs = ^{pc[1:0], next_pc[1:0]};
   assign occ    = buf_cnt_q + out_cnt_q;
   assign accept = imem_req_valid & imem_req_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  if (pc_select && !accept) state_d = REPLAY;
         REPLAY: if (accept && !pc_select) state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Outputs; the very first request after reset targets RESET_PC and leaves the PC alone
   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = {next_pc[31:2], 2'b00};
      pc_stall       = 1'b1;
      if (reset) begin
         imem_req_valid = (occ < DEPTH_C);
         case (state_q)
            FETCH: begin
               if (first_q && !pc_select) begin
                  imem_req_addr = {RESET_PC[31:2], 2'b00};
               end else begin
                  pc_stall = !(imem_req_valid & imem_req_ready) & !pc_select;
               end
            end
            default: imem_req_addr = {pc[31:2], 2'b00};
         endcase
      end
   end

   assign kill_nz   = (kill_q != '0);
   assign resp_live = imem_resp_valid & !kill_nz;
   assign iv_buf    = reset & (buf_cnt_q != '0) & !pc_select;
   assign pop       = iv_buf & inst_ready;
`ifdef FETCH_BYPASS_EN
   assign byp = reset & resp_live & (buf_cnt_q == '0) & inst_ready & !pc_select;
`else
   assign byp = 1'b0;
`endif
   assign push       = resp_live & !pc_select & !byp;
   assign inst_valid = iv_buf | byp;
   assign inst_data  = byp ? imem_resp_data    : ib_data[ib_rd_q];
   assign inst_pc    = byp ? pcf_mem[pcf_rd_q] : ib_pc[ib_rd_q];

   // Redirect kills everything outstanding before this cycle, less the response landing now
   always_comb begin
      first_d   = first_q & !accept & !pc_select;
      out_cnt_d = out_cnt_q + CW'(accept) - CW'(imem_resp_valid);
      buf_cnt_d = pc_select ? '0 : buf_cnt_q + CW'(push) - CW'(pop);
      kill_d    = pc_select ? out_cnt_q - CW'(imem_resp_valid)
                            : kill_q - CW'(imem_resp_valid & kill_nz);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         first_q   <= 1'b1;
         out_cnt_q <= '0;
         buf_cnt_q <= '0;
         kill_q    <= '0;
         pcf_wr_q  <= '0;
         pcf_rd_q  <= '0;
         ib_wr_q   <= '0;
         ib_rd_q   <= '0;
      end else begin
         first_q   <= first_d;
         out_cnt_q <= out_cnt_d;
         buf_cnt_q <= buf_cnt_d;
         kill_q    <= kill_d;
         pcf_wr_q  <= pcf_wr_q + AW'(accept);
         pcf_rd_q  <= pcf_rd_q + AW'(imem_resp_valid);
         if (pc_select) begin
            ib_wr_q <= '0;
            ib_rd_q <= '0;
         end else begin
            ib_wr_q <= ib_wr_q + AW'(push);
            ib_rd_q <= ib_rd_q + AW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pcf_mem[pcf_wr_q] <= imem_req_addr;
      if (push) begin
         ib_pc[ib_wr_q]   <= pcf_mem[pcf_rd_q];
         ib_data[ib_wr_q] <= imem_resp_data;
      end
   end

endmodule
